// File: rtl/fetch_queue_stage.sv
// Instruction fetch stage: PC generation, 1-cycle imem interface and a DEPTH-entry prefetch FIFO.
// Optional BTB-directed next-PC selection is enabled by defining FETCH_BTB_PREDICT_EN.
module fetch_queue_stage #(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 4,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_en,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic [XLEN-1:0] btb_target_pc,
  input  logic            btb_pc_valid,
  input  logic            btb_pc_predictTaken,
  output logic            imem_en,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            out_pred_taken,
  output logic [XLEN-1:0] pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic            pred_mem  [DEPTH];

  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic [CW:0]     occupancy;
  logic            inflight, kill;
  logic [XLEN-1:0] fl_pc, head_pc_q, next_pc;
  logic            fl_pred, pred, push, deq;

`ifdef FETCH_BTB_PREDICT_EN
  assign pred    = btb_pc_valid & btb_pc_predictTaken;
  assign next_pc = pred ? btb_target_pc : pc + XLEN'(4);
`else
  logic unused_btb;
  assign pred       = 1'b0;
  assign next_pc    = pc + XLEN'(4);
  assign unused_btb = ^{btb_target_pc, btb_pc_valid, btb_pc_predictTaken, pred_mem[rd_ptr]};
`endif

  assign out_valid = (count != '0);
  assign deq       = out_valid & out_ready;
  // A response is kept only if no redirect flushed it this cycle or last cycle.
  assign push      = inflight & ~kill & ~redirect_en;

  // In-flight request still needs a slot, a popping head frees one.
  assign occupancy = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(deq);
  assign imem_en   = ~rst & ~redirect_en & (occupancy < (CW+1)'(DEPTH));
  assign imem_addr = pc;

  assign out_instr = out_valid ? instr_mem[rd_ptr] : NOP_INSTR;
  assign out_pc    = out_valid ? pc_mem[rd_ptr]    : head_pc_q;
`ifdef FETCH_BTB_PREDICT_EN
  assign out_pred_taken = out_valid & pred_mem[rd_ptr];
`else
  assign out_pred_taken = 1'b0;
`endif

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_PC;
      inflight  <= 1'b0;
      kill      <= 1'b0;
      fl_pc     <= '0;
      fl_pred   <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      head_pc_q <= '0;
    end else begin
      kill <= redirect_en & inflight;
      if (out_valid) head_pc_q <= out_pc;
      if (redirect_en) begin
        pc       <= redirect_pc;
        inflight <= 1'b0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        inflight <= imem_en;
        if (imem_en) begin
          fl_pc   <= pc;
          fl_pred <= pred;
          pc      <= next_pc;
        end
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (deq)  rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(deq);
      end
    end
  end

  // NOTE: FIFO storage has no reset; count gates every read so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]    <= fl_pc;
      pred_mem[wr_ptr]  <= fl_pred;
    end
  end

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed self-checking bench for fetch_queue_stage; honours FETCH_BTB_PREDICT_EN when defined.
module tb_fetch_queue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic [31:0] btb_target_pc;
  logic        btb_pc_valid;
  logic        btb_pc_predictTaken;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_pred_taken;
  logic [31:0] pc;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] MSK = 32'hA5A5_0000;

  fetch_queue_stage dut (
    .clk(clk), .rst(rst),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .btb_target_pc(btb_target_pc), .btb_pc_valid(btb_pc_valid),
    .btb_pc_predictTaken(btb_pc_predictTaken),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_pred_taken(out_pred_taken), .pc(pc)
  );

  always #5 clk = ~clk;

  // Instruction memory model: 1-cycle read latency, data = addr ^ A5A5_0000.
  always @(posedge clk) if (imem_en) imem_rdata <= imem_addr ^ MSK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic reset_outputs(input string tag);
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_instr"}, out_instr, NOP);
    check({tag, "_pc"}, out_pc, 32'd0);
    check({tag, "_pred"}, {31'b0, out_pred_taken}, 32'd0);
    check({tag, "_en"}, {31'b0, imem_en}, 32'd0);
    check({tag, "_fpc"}, pc, 32'd0);
  endtask

  logic [31:0] exp_btb_addr;
  logic        exp_btb_pred;

  initial begin
`ifdef FETCH_BTB_PREDICT_EN
    exp_btb_addr = 32'h100; exp_btb_pred = 1'b1;
`else
    exp_btb_addr = 32'h00C; exp_btb_pred = 1'b0;
`endif
    rst = 1'b1; redirect_en = 1'b0; redirect_pc = '0; btb_target_pc = '0;
    btb_pc_valid = 1'b0; btb_pc_predictTaken = 1'b0; out_ready = 1'b1;
    imem_rdata = '0;

    // Reset state and streaming with out_ready=1.
    @(negedge clk); @(negedge clk); #1;
    reset_outputs("rst");
    @(negedge clk); rst = 1'b0; #1;
    check("s_en0", {31'b0, imem_en}, 32'd1);
    check("s_addr0", imem_addr, 32'h0);
    @(negedge clk); #1;
    check("s_addr1", imem_addr, 32'h4);
    check("s_nv1", {31'b0, out_valid}, 32'd0);
    @(negedge clk); #1;
    check("s_addr2", imem_addr, 32'h8);
    check("s_v2", {31'b0, out_valid}, 32'd1);
    check("s_pc2", out_pc, 32'h0);
    check("s_in2", out_instr, 32'hA5A5_0000);
    @(negedge clk); #1;
    check("s_addr3", imem_addr, 32'hC);
    check("s_pc3", out_pc, 32'h4);
    @(negedge clk); #1;
    check("s_pc4", out_pc, 32'h8);
    check("s_in4", out_instr, 32'hA5A5_0008);

    // Stall with out_ready=0 from reset: exactly DEPTH entries, then hold.
    @(negedge clk); rst = 1'b1; out_ready = 1'b0;
    @(negedge clk); rst = 1'b0; #1;
    check("f_addr0", imem_addr, 32'h0);
    @(negedge clk); @(negedge clk); @(negedge clk); #1;
    check("f_en3", {31'b0, imem_en}, 32'd1);
    check("f_addr3", imem_addr, 32'hC);
    @(negedge clk); #1;
    check("f_en4", {31'b0, imem_en}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      check("f_hold_en", {31'b0, imem_en}, 32'd0);
      check("f_hold_pc", pc, 32'h10);
      check("f_hold_head", out_pc, 32'h0);
    end
    @(negedge clk); out_ready = 1'b1; #1;
    check("d_pc0", out_pc, 32'h0);
    check("d_en", {31'b0, imem_en}, 32'd1);
    check("d_addr", imem_addr, 32'h10);
    @(negedge clk); #1; check("d_pc4", out_pc, 32'h4);
    @(negedge clk); #1; check("d_pc8", out_pc, 32'h8);
    @(negedge clk); #1; check("d_pcC", out_pc, 32'hC);
    @(negedge clk); #1;
    check("d_pc10", out_pc, 32'h10);
    check("d_in10", out_instr, 32'hA5A5_0010);

    // Redirect with 3 queued entries and one request in flight.
    redirect_en = 1'b1; redirect_pc = 32'h200; #1;
    check("r_en", {31'b0, imem_en}, 32'd0);
    @(negedge clk); redirect_en = 1'b0; #1;
    check("r_nv", {31'b0, out_valid}, 32'd0);
    check("r_nop", out_instr, NOP);
    check("r_lastpc", out_pc, 32'h10);
    check("r_addr", imem_addr, 32'h200);
    @(negedge clk); #1;
    check("r_nv2", {31'b0, out_valid}, 32'd0);
    check("r_addr2", imem_addr, 32'h204);
    @(negedge clk); #1;
    check("r_v", {31'b0, out_valid}, 32'd1);
    check("r_pc", out_pc, 32'h200);
    check("r_in", out_instr, 32'hA5A5_0200);

    // BTB-directed fetch at pc 0x8.
    redirect_en = 1'b1; redirect_pc = 32'h8;
    @(negedge clk); redirect_en = 1'b0;
    btb_pc_valid = 1'b1; btb_pc_predictTaken = 1'b1; btb_target_pc = 32'h100; #1;
    check("b_addr8", imem_addr, 32'h8);
    @(negedge clk); btb_pc_valid = 1'b0; btb_pc_predictTaken = 1'b0; #1;
    check("b_next", imem_addr, exp_btb_addr);
    @(negedge clk); #1;
    check("b_pc", out_pc, 32'h8);
    check("b_pred", {31'b0, out_pred_taken}, {31'b0, exp_btb_pred});
    @(negedge clk); #1;
    check("b_pc2", out_pc, exp_btb_addr);
    check("b_pred2", {31'b0, out_pred_taken}, 32'd0);

    // Asynchronous reset while the FIFO is filling/full.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    #2 rst = 1'b1; #1;
    reset_outputs("ar");
    @(negedge clk); rst = 1'b0; out_ready = 1'b1; #1;
    check("ar_addr", imem_addr, 32'h0);
    check("ar_nv", {31'b0, out_valid}, 32'd0);
    @(negedge clk); #1;
    check("ar_nv2", {31'b0, out_valid}, 32'd0);
    @(negedge clk); #1;
    check("ar_pc", out_pc, 32'h0);
    check("ar_in", out_instr, 32'hA5A5_0000);

    // PC wrap from FFFF_FFFC to 0.
    redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk); redirect_en = 1'b0; #1;
    check("w_addr", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk); #1;
    check("w_wrap", imem_addr, 32'h0);
    @(negedge clk); #1;
    check("w_pc", out_pc, 32'hFFFF_FFFC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
